// File: rtl/y86_mem_responder.sv
// Byte-addressed RAM behind the y86 core bus, with a preload port whose LOAD/RUN FSM
// holds the core in reset until the image is loaded. Optional feature macro: MEM_WATCH_EN.
module y86_mem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cpu_addr,
    input  logic             cpu_re,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_hold,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [7:0]       ld_data,
    input  logic             ld_done,
    output logic             oob_err,
    output logic             col_err,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
`ifdef MEM_WATCH_EN
    ,
    input  logic [31:0]      watch_addr,
    output logic             watch_hit
`endif
);

    localparam int          AW     = $clog2(DEPTH_BYTES);
    localparam logic [31:0] LAST_A = 32'(DEPTH_BYTES - 4);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t           state_q;
    logic             cpu_hold_q;
    logic             ld_ready_q;
    logic             oob_q;
    logic             col_q;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [7:0]       mem_q [DEPTH_BYTES];

    logic             run;
    logic             in_range;
    logic             wr_en;
    logic             pl_en;
    logic [AW-1:0]    cpu_idx;
    logic [AW-1:0]    ld_idx;
    logic [31:0]      rdata;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Range check is on the full address so high addresses never alias into the array.
    assign run      = (state_q == ST_RUN);
    assign in_range = (cpu_addr <= LAST_A);
    assign cpu_idx  = AW'(cpu_addr);
    assign ld_idx   = AW'(ld_addr);
    assign wr_en    = run && cpu_we && in_range && !rst;
    assign pl_en    = !run && ld_valid && !rst;

    always_comb begin
        rdata = '0;
        if (run && cpu_re && in_range) begin
            for (int k = 0; k < 4; k++) begin
                rdata[8*k +: 8] = mem_q[cpu_idx + AW'(k)];
            end
        end
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (cpu_re) rd_cnt_d = sat_inc(rd_cnt_q);
        if (cpu_we) wr_cnt_d = sat_inc(wr_cnt_q);
    end

    // Storage is deliberately left out of reset so a reset mid-load keeps the bytes already written.
    always_ff @(posedge clk) begin
        if (pl_en) begin
            mem_q[ld_idx] <= ld_data;
        end
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[cpu_idx + AW'(k)] <= cpu_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            cpu_hold_q <= 1'b1;
            ld_ready_q <= 1'b1;
            oob_q      <= 1'b0;
            col_q      <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (ld_done) begin
                        state_q    <= ST_RUN;
                        cpu_hold_q <= 1'b0;
                        ld_ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    rd_cnt_q <= rd_cnt_d;
                    wr_cnt_q <= wr_cnt_d;
                    if ((cpu_re || cpu_we) && !in_range) oob_q <= 1'b1;
                    if (cpu_re && cpu_we)                col_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

`ifdef MEM_WATCH_EN
    logic        watch_hit_q;
    logic [31:0] watch_off;

    assign watch_off = watch_addr - cpu_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            watch_hit_q <= 1'b0;
        end else begin
            watch_hit_q <= wr_en && (watch_addr >= cpu_addr) && (watch_off < 32'd4);
        end
    end

    assign watch_hit = watch_hit_q;
`endif

    assign cpu_rdata = rdata;
    assign cpu_hold  = cpu_hold_q;
    assign ld_ready  = ld_ready_q;
    assign oob_err   = oob_q;
    assign col_err   = col_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_y86_mem_responder.sv
// Bench for y86_mem_responder: directed cases plus randomized core traffic checked
// against a byte-array reference model. Exercises the watch port when MEM_WATCH_EN is defined.
module tb_y86_mem_responder;

    localparam int          DEPTH = 1024;
    localparam int          CW    = 4;
    localparam int          SAT   = (1 << CW) - 1;
    localparam logic [31:0] LAST  = 32'(DEPTH - 4);

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   cpu_addr;
    logic          cpu_re;
    logic          cpu_we;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_hold;
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_addr;
    logic [7:0]    ld_data;
    logic          ld_done;
    logic          oob_err;
    logic          col_err;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] wr_count;
`ifdef MEM_WATCH_EN
    logic [31:0]   watch_addr;
    logic          watch_hit;
`endif

    always #5 clk = ~clk;

    y86_mem_responder #(.DEPTH_BYTES(DEPTH), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_hold  (cpu_hold),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .oob_err   (oob_err),
        .col_err   (col_err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`ifdef MEM_WATCH_EN
        ,
        .watch_addr(watch_addr),
        .watch_hit (watch_hit)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain byte array plus the architectural status values.
    logic [7:0] ref_mem [DEPTH];
    bit         ref_run;
    bit         ref_oob;
    bit         ref_col;
    int         ref_rd;
    int         ref_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (a > LAST) return 32'h0;
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".hold"},  32'(cpu_hold), 32'(!ref_run));
        check({tag, ".ready"}, 32'(ld_ready), 32'(!ref_run));
        check({tag, ".oob"},   32'(oob_err),  32'(ref_oob));
        check({tag, ".col"},   32'(col_err),  32'(ref_col));
        check({tag, ".rdcnt"}, 32'(rd_count), 32'(ref_rd));
        check({tag, ".wrcnt"}, 32'(wr_count), 32'(ref_wr));
    endtask

    task automatic idle_inputs();
        cpu_re   = 1'b0;
        cpu_we   = 1'b0;
        ld_valid = 1'b0;
        ld_done  = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        ref_run = 1'b0;
        ref_oob = 1'b0;
        ref_col = 1'b0;
        ref_rd  = 0;
        ref_wr  = 0;
        #1;
        rst = 1'b0;
        check_status(tag);
`ifdef MEM_WATCH_EN
        check({tag, ".watch"}, 32'(watch_hit), 32'h0);
`endif
    endtask

    // One preload byte; the core strobes carry random junk that must be ignored in LOAD.
    task automatic pl_byte(input int a, input logic [7:0] d, input bit done);
        ld_valid  = 1'b1;
        ld_addr   = 32'(a) + (32'($urandom_range(0, 7)) << 10);
        ld_data   = d;
        ld_done   = done;
        cpu_re    = 1'($urandom_range(0, 1));
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 32'($urandom_range(0, 2047));
        cpu_wdata = $urandom;
        #1;
        check("load.rdata", cpu_rdata, 32'h0);
        @(posedge clk);
        ref_mem[a % DEPTH] = d;
        if (done) ref_run = 1'b1;
        #1;
        idle_inputs();
        check_status("load");
    endtask

    task automatic cpu_cycle(input logic re, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input string tag);
        logic [31:0] exp_rd;
        cpu_re    = re;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        if (ref_run) begin
            ld_valid = 1'($urandom_range(0, 1));
            ld_done  = 1'($urandom_range(0, 1));
            ld_addr  = $urandom;
            ld_data  = 8'($urandom);
        end
        #1;
        exp_rd = (ref_run && re) ? ref_read(a) : 32'h0;
        check({tag, ".rdata"}, cpu_rdata, exp_rd);
        @(posedge clk);
        if (ref_run) begin
            if (re && ref_rd < SAT) ref_rd++;
            if (we && ref_wr < SAT) ref_wr++;
            if ((re || we) && a > LAST) ref_oob = 1'b1;
            if (re && we) ref_col = 1'b1;
            if (we && a <= LAST) begin
                for (int k = 0; k < 4; k++) ref_mem[a+k] = wd[8*k +: 8];
            end
        end
        #1;
        idle_inputs();
        check_status(tag);
    endtask

    logic [7:0]  t1_img [4];
    logic [31:0] ra;
    int          sel;

    initial begin
        t1_img    = '{8'h01, 8'hF4, 8'h89, 8'h45};
        rst       = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ld_addr   = '0;
        ld_data   = '0;
        idle_inputs();
`ifdef MEM_WATCH_EN
        watch_addr = 32'h22;
`endif
        do_reset("reset0");
        do_reset("reset1");

        // T1: full image with T1 bytes at 0..3; last byte arrives together with ld_done.
        for (int a = 0; a < DEPTH; a++) begin
            pl_byte(a, (a < 4) ? t1_img[a] : 8'($urandom), a == DEPTH - 1);
        end
        check("T1.hold_fell", 32'(cpu_hold), 32'h0);
        cpu_cycle(1'b1, 1'b0, 32'h0, 32'h0, "T1");
        cpu_re   = 1'b1;
        cpu_addr = 32'h0;
        #1;
        check("T1.const", cpu_rdata, 32'h4589F401);
        idle_inputs();

        // T2: unaligned write, read back straddling it.
        cpu_cycle(1'b0, 1'b1, 32'h100, 32'h0, "T2.clr");
        cpu_cycle(1'b0, 1'b1, 32'h101, 32'hDEADBEEF, "T2.wr");
        cpu_cycle(1'b1, 1'b0, 32'h100, 32'h0, "T2.rd");
        cpu_re   = 1'b1;
        cpu_addr = 32'h100;
        #1;
        check("T2.const", cpu_rdata, 32'hADBEEF00);
        idle_inputs();

        // T3: out-of-range accesses at and past the boundary.
        cpu_cycle(1'b1, 1'b0, LAST + 1, 32'h0, "T3.rd");
        cpu_cycle(1'b0, 1'b1, LAST + 1, 32'hFFFFFFFF, "T3.wr");
        cpu_cycle(1'b1, 1'b0, LAST, 32'h0, "T3.last");
        cpu_cycle(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, "T3.wrap");
        cpu_cycle(1'b0, 1'b1, 32'(DEPTH), 32'h12345678, "T3.wr2");
        cpu_cycle(1'b1, 1'b0, 32'h0, 32'h0, "T3.low");

        // T4: collision returns pre-write data.
        cpu_cycle(1'b0, 1'b1, 32'h10, 32'h11111111, "T4.init");
        cpu_cycle(1'b1, 1'b1, 32'h10, 32'h22222222, "T4.col");
        cpu_cycle(1'b1, 1'b0, 32'h10, 32'h0, "T4.after");

        // Random traffic, biased towards the boundary; counters saturate along the way.
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       ra = 32'($urandom_range(0, DEPTH - 4));
            else if (sel == 7) ra = 32'($urandom_range(DEPTH - 7, DEPTH - 1));
            else if (sel == 8) ra = 32'($urandom_range(16'h20, 16'h30));
            else               ra = $urandom;
            cpu_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), ra, $urandom, "rand");
        end

        // T5: reset mid-run, then reset mid-load; preloaded bytes survive.
        do_reset("T5.runrst");
        pl_byte(32'h200, 8'hAA, 1'b0);
        pl_byte(32'h201, 8'hBB, 1'b0);
        do_reset("T5.ldrst");
        pl_byte(32'h202, 8'hCC, 1'b0);
        pl_byte(32'h203, 8'hDD, 1'b1);
        cpu_cycle(1'b1, 1'b0, 32'h200, 32'h0, "T5.rd");
        cpu_re   = 1'b1;
        cpu_addr = 32'h200;
        #1;
        check("T5.const", cpu_rdata, 32'hDDCCBBAA);
        idle_inputs();

`ifdef MEM_WATCH_EN
        // T6: a write covering watch_addr pulses watch_hit for exactly one cycle.
        cpu_cycle(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, "T6.hit");
        check("T6.hit", 32'(watch_hit), 32'h1);
        @(posedge clk);
        #1;
        check("T6.pulse", 32'(watch_hit), 32'h0);
        cpu_cycle(1'b0, 1'b1, 32'h23, 32'h0BADF00D, "T6.miss");
        check("T6.miss", 32'(watch_hit), 32'h0);
        cpu_cycle(1'b0, 1'b1, 32'h1F, 32'h01020304, "T6.edge");
        check("T6.edge", 32'(watch_hit), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
